// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store engine.
//
// Turns the EX/MEM memory control fields into one handshaked word transaction
// on the data-memory bus, with byte-lane steering for stores, sign/zero
// extension for loads and misalignment detection. stall_MEM freezes the
// upstream pipeline while a transaction is outstanding.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction that has not
// been acknowledged within TIMEOUT_CYCLES WAIT cycles (bus_error pulse).
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   MemRead_MEM[2:0]    001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, else none
//   MemWrite_MEM[1:0]   01 SB, 10 SH, 11 SW, 00 none (a write wins over a read)
//   AluResult_MEM[31:0] byte address
//   WriteMemData_MEM    right-aligned store data
//   dmem_*              registered bus request/address/enables/data, ack/rdata in
//   ReadData_MEM        registered extended load result; load_done pulses on update
//   stall_MEM           combinational pipeline freeze
//   addr_error          combinational misalignment pulse (IDLE only)
//   bus_error           timeout abort pulse (0 unless MEM_TIMEOUT_EN)
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  MemRead_MEM,
    input  logic [1:0]  MemWrite_MEM,
    input  logic [31:0] AluResult_MEM,
    input  logic [31:0] WriteMemData_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadData_MEM,
    output logic        load_done,
    output logic        stall_MEM,
    output logic        addr_error,
    output logic        bus_error
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t state, state_next;

    logic        is_wr, is_rd, req_present, misaligned;
    size_t       size_c;
    logic        signed_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    logic        start, complete, timeout;

    // Attributes of the in-flight load, kept for extension at ack time
    logic        lat_load, lat_signed;
    size_t       lat_size;
    logic [1:0]  lat_off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Request decode, alignment and lane steering
    always_comb begin
        is_wr       = (MemWrite_MEM != 2'b00);
        is_rd       = (MemRead_MEM >= 3'd1) && (MemRead_MEM <= 3'd5);
        req_present = is_wr || is_rd;
        size_c      = SZ_W;
        signed_c    = 1'b0;
        if (is_wr) begin
            case (MemWrite_MEM)
                2'b01:   size_c = SZ_B;
                2'b10:   size_c = SZ_H;
                default: size_c = SZ_W;
            endcase
        end else begin
            case (MemRead_MEM)
                3'b001:  begin size_c = SZ_B; signed_c = 1'b1; end
                3'b010:  size_c = SZ_B;
                3'b011:  begin size_c = SZ_H; signed_c = 1'b1; end
                3'b100:  size_c = SZ_H;
                default: size_c = SZ_W;
            endcase
        end
        misaligned = ((size_c == SZ_H) && AluResult_MEM[0]) ||
                     ((size_c == SZ_W) && (AluResult_MEM[1:0] != 2'b00));

        case (size_c)
            SZ_B: begin
                be_c    = 4'b0001 << AluResult_MEM[1:0];
                wdata_c = {4{WriteMemData_MEM[7:0]}};
            end
            SZ_H: begin
                be_c    = AluResult_MEM[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{WriteMemData_MEM[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = WriteMemData_MEM;
            end
        endcase
        if (!is_wr) begin
            wdata_c = '0;
        end
    end

    assign stall_MEM  = req_present && !misaligned && (state != S_DONE);
    assign addr_error = (state == S_IDLE) && req_present && misaligned;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          bus_error_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= timeout;
            if (start) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign bus_error = bus_error_q;
`else
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // dmem_req is high exactly while in WAIT, so ack is only honoured there
    always_comb begin
        state_next = state;
        start      = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_present && !misaligned) begin
                    state_next = S_WAIT;
                    start      = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    state_next = S_DONE;
                    complete   = 1'b1;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = S_DONE;
                    timeout    = 1'b1;
                end
`endif
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Load lane selection and extension from the latched offset/size
    always_comb begin
        case (lat_off)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_size)
            SZ_B:    load_ext = {{24{lat_signed & byte_sel[7]}}, byte_sel};
            SZ_H:    load_ext = {{16{lat_signed & half_sel[15]}}, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            ReadData_MEM <= '0;
            load_done    <= 1'b0;
            lat_load     <= 1'b0;
            lat_signed   <= 1'b0;
            lat_size     <= SZ_W;
            lat_off      <= '0;
        end else begin
            load_done <= 1'b0;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_wr;
                dmem_addr  <= {AluResult_MEM[31:2], 2'b00};
                dmem_be    <= be_c;
                dmem_wdata <= wdata_c;
                lat_load   <= !is_wr;
                lat_signed <= signed_c;
                lat_size   <= size_c;
                lat_off    <= AluResult_MEM[1:0];
            end
            if (complete || timeout) begin
                dmem_req <= 1'b0;
            end
            if (complete && lat_load) begin
                ReadData_MEM <= load_ext;
                load_done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  MemRead_MEM;
    logic [1:0]  MemWrite_MEM;
    logic [31:0] AluResult_MEM;
    logic [31:0] WriteMemData_MEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadData_MEM;
    logic        load_done, stall_MEM, addr_error, bus_error;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .AluResult_MEM(AluResult_MEM), .WriteMemData_MEM(WriteMemData_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .ReadData_MEM(ReadData_MEM), .load_done(load_done),
        .stall_MEM(stall_MEM), .addr_error(addr_error), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] ld_q[$];
    int          err_q[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_rd = '0;
    logic        prev_req = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},   {31'b0, dmem_req},   32'd0);
        chk({tag, "_we"},    {31'b0, dmem_we},    32'd0);
        chk({tag, "_addr"},  dmem_addr,           32'd0);
        chk({tag, "_be"},    {28'b0, dmem_be},    32'd0);
        chk({tag, "_wdata"}, dmem_wdata,          32'd0);
        chk({tag, "_rdata"}, ReadData_MEM,        32'd0);
        chk({tag, "_ldone"}, {31'b0, load_done},  32'd0);
        chk({tag, "_stall"}, {31'b0, stall_MEM},  32'd0);
        chk({tag, "_aerr"},  {31'b0, addr_error}, 32'd0);
        chk({tag, "_berr"},  {31'b0, bus_error},  32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    always @(negedge clock) begin
        bus_t e;
        logic exp_err;
        if (reset_n) begin
            if (dmem_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: got addr %h expected none", dmem_addr);
                end else begin
                    e = bus_q.pop_front();
                    chk("req_addr",  dmem_addr,          e.addr);
                    chk("req_we",    {31'b0, dmem_we},   {31'b0, e.we});
                    chk("req_be",    {28'b0, dmem_be},   {28'b0, e.be});
                    chk("req_wdata", dmem_wdata,         e.wdata);
                end
            end
            if (load_done) begin
                if (ld_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_load_done: got %h expected none", ReadData_MEM);
                end else begin
                    last_rd = ld_q.pop_front();
                    chk("load_data", ReadData_MEM, last_rd);
                end
            end else begin
                chk("rdata_hold", ReadData_MEM, last_rd);
            end
            exp_err = (err_q.size() != 0) && (err_q[0] == cyc);
            if (exp_err) void'(err_q.pop_front());
            if (exp_err || addr_error)
                chk("addr_error", {31'b0, addr_error}, {31'b0, exp_err});
            chk("bus_error", {31'b0, bus_error}, 32'd0);
        end
        prev_req = dmem_req;
    end

    task automatic clear_inputs();
        MemRead_MEM      = '0;
        MemWrite_MEM     = '0;
        AluResult_MEM    = '0;
        WriteMemData_MEM = '0;
    endtask

    // Issues one MEM-stage instruction, acts as memory, and pushes expectations
    task automatic do_op(input logic [2:0] rd, input logic [1:0] wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] w, input int k);
        int          n, stall_cnt;
        bit          ld, sg;
        logic [31:0] be32, mask, v;
        bus_t        e;
        ld = 0; sg = 0; n = 0;
        if (wr != 2'b00) begin
            n = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
        end else if (rd >= 3'd1 && rd <= 3'd5) begin
            ld = 1;
            n  = (rd <= 3'd2) ? 1 : (rd <= 3'd4) ? 2 : 4;
            sg = (rd == 3'd1) || (rd == 3'd3);
        end

        @(posedge clock); #1;
        MemRead_MEM = rd; MemWrite_MEM = wr; AluResult_MEM = a; WriteMemData_MEM = d;
        dmem_ack = 1'b0;

        if (n == 0) begin
            @(negedge clock);
            chk("none_stall", {31'b0, stall_MEM}, 32'd0);
        end else if ((int'(a[1:0]) % n) != 0) begin
            err_q.push_back(cyc);
            @(negedge clock);
            chk("mis_stall", {31'b0, stall_MEM}, 32'd0);
            chk("mis_req",   {31'b0, dmem_req},  32'd0);
        end else begin
            be32    = ((32'd1 << n) - 32'd1) << a[1:0];
            e.addr  = a & ~32'd3;
            e.we    = (wr != 2'b00);
            e.be    = be32[3:0];
            e.wdata = (n == 1) ? (d & 32'hFF) * 32'h01010101 :
                      (n == 2) ? (d & 32'hFFFF) * 32'h00010001 : d;
            if (ld) e.wdata = '0;
            bus_q.push_back(e);
            if (ld) begin
                mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
                v    = (w >> (8 * a[1:0])) & mask;
                if (sg && n < 4 && v[8 * n - 1]) v = v | ~mask;
                ld_q.push_back(v);
            end
            stall_cnt = 0;
            @(negedge clock);
            if (stall_MEM) stall_cnt++;
            repeat (k) begin
                @(posedge clock); #1;
                @(negedge clock);
                if (stall_MEM) stall_cnt++;
            end
            @(posedge clock); #1;
            dmem_ack = 1'b1; dmem_rdata = w;
            @(negedge clock);
            if (stall_MEM) stall_cnt++;
            @(posedge clock); #1;
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            @(negedge clock);
            chk("done_stall", {31'b0, stall_MEM}, 32'd0);
            chk("done_req",   {31'b0, dmem_req},  32'd0);
            chk("stall_cycles", stall_cnt, k + 2);
        end
        // Idle cycle afterwards; a stray ack here has no request to complete
        @(posedge clock); #1;
        clear_inputs();
        dmem_ack = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [2:0] rd;
        logic [1:0] wr;
        logic [31:0] a;
        int r;
        reset_n = 1'b0;
        clear_inputs();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;

        do_op(3'd5, 2'd0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2);
        do_op(3'd1, 2'd0, 32'h0000_0103, 32'h0,         32'h8012_3456, 0);
        do_op(3'd2, 2'd0, 32'h0000_0103, 32'h0,         32'h8012_3456, 1);
        do_op(3'd0, 2'd2, 32'h0000_0202, 32'h0000_ABCD, 32'h0,         0);
        do_op(3'd0, 2'd3, 32'h0000_0301, 32'h1234_5678, 32'h0,         0);
        do_op(3'd3, 2'd0, 32'h0000_0305, 32'h0,         32'h0,         0);

        // Asynchronous reset while a load is waiting for ack
        @(posedge clock); #1;
        MemRead_MEM = 3'd5; AluResult_MEM = 32'h0000_0400; dmem_ack = 1'b0;
        bus_q.push_back('{addr: 32'h0000_0400, we: 1'b0, be: 4'hF, wdata: 32'h0});
        @(posedge clock); #1;
        @(negedge clock);
        chk("wait_req", {31'b0, dmem_req}, 32'd1);
        #1;
        clear_inputs();
        last_rd = '0;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clock); #1;
        reset_n = 1'b1;

        do_op(3'd0, 2'd1, 32'h0000_0001, 32'h0000_0077, 32'h0, 1);

        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            rd = 3'($urandom_range(0, 7));
            wr = (r < 4) ? 2'($urandom_range(1, 3)) : 2'd0;
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(rd, wr, a, $urandom, $urandom, $urandom_range(0, 4));
        end

        repeat (3) @(negedge clock);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("ld_q_empty",  ld_q.size(),  32'd0);
        chk("err_q_empty", err_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store engine. It sits on the consumer side of the EX/MEM pipeline register and turns its memory control and data fields into handshaked word transactions on the data-memory bus. It handles byte-lane steering, load extension and misalignment detection. While a transaction is outstanding it asserts a stall to the hazard unit, which freezes IF through EX/MEM.

Parameters:
TIMEOUT_CYCLES, 16, cycles to wait for dmem_ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
MemRead_MEM  input  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110/111 treated as none
MemWrite_MEM  input  2  00 none, 01 SB, 10 SH, 11 SW
AluResult_MEM  input  32  byte address
WriteMemData_MEM  input  32  store data, right-aligned
dmem_req  output  1  bus request, registered
dmem_we  output  1  1 = write
dmem_addr  output  32  word address, {addr[31:2],2'b00}
dmem_be  output  4  byte enables; bit i = byte lane i (little-endian)
dmem_wdata  output  32  lane-steered store data
dmem_ack  input  1  memory completion, sampled only while dmem_req=1
dmem_rdata  input  32  read word, valid with dmem_ack
ReadData_MEM  output  32  extended load result, registered
load_done  output  1  one-cycle pulse when ReadData_MEM is updated
stall_MEM  output  1  combinational; freeze pipeline
addr_error  output  1  one-cycle pulse, misaligned access
bus_error  output  1  one-cycle pulse, timeout abort

Behaviour:
- Request present: rd = MemRead_MEM in 001..101, or wr = MemWrite_MEM != 00. If both are set, the write wins.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
- FSM states are IDLE, WAIT and DONE.
- IDLE, aligned request:
  - Next edge: dmem_req=1; dmem_addr, dmem_we, dmem_be and dmem_wdata latched from the request; go to WAIT.
- IDLE, misaligned request:
  - No bus request is issued.
  - addr_error=1 during that cycle (combinational, qualified by IDLE); stall_MEM=0; stay in IDLE.
- WAIT:
  - dmem_req and all dmem_* outputs are held stable until dmem_ack=1 is sampled.
  - On ack: dmem_req drops at that edge; for a load, ReadData_MEM is captured and load_done is set for one cycle; go to DONE.
- DONE: one cycle, then IDLE. This lets the EX/MEM register advance so the same instruction is never reissued.
- stall_MEM = request present AND aligned AND state != DONE.
  - Minimum latency with ack in the first WAIT cycle: 2 stall cycles and 1 DONE cycle.
- Store steering:
  - SB: wdata = {4{byte}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{half}}, be = 4'b0011 if addr[1]=0, else 4'b1100.
  - SW: wdata unchanged, be = 4'b1111.
- Loads:
  - dmem_be is the same lane mask as the matching store size; dmem_wdata=0.
  - Byte/half is selected by addr[1:0] or addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- ReadData_MEM holds its value until the next completed load; it is unchanged by stores and errors.
- dmem_ack while dmem_req=0 is ignored.
- Reset (asynchronous, any state including WAIT):
  - State goes to IDLE; the in-flight transaction is abandoned.
  - All outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ReadData_MEM, load_done, addr_error, bus_error. stall_MEM is 0 because the state is IDLE with no request.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter runs in WAIT and clears on entry.
- If it reaches TIMEOUT_CYCLES without ack: dmem_req drops, bus_error pulses for one cycle, the FSM goes to DONE, and ReadData_MEM is not updated.
- Undefined: no counter exists, WAIT persists indefinitely, and bus_error is tied 0.

Test Plan:
- LW at addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF:
  - dmem_be=1111; ReadData_MEM=0xDEADBEEF; load_done is one pulse; stall_MEM is high for 4 cycles, then low in DONE.
- LB at 0x103 with rdata 0x80123456 -> ReadData_MEM=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202 with data 0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, ReadData_MEM unchanged.
- SW at 0x301 -> addr_error pulses; dmem_req stays 0; stall_MEM=0. LH at 0x305 -> same.
- reset_n low while in WAIT -> dmem_req=0 immediately (asynchronous). A following SB at 0x001 with data 0x77 -> dmem_be=0010, dmem_wdata=0x77777777.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, LW with no ack:
  - bus_error pulses after 16 WAIT cycles; stall_MEM is released in DONE; ReadData_MEM is unchanged.
